// File: rtl/acc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package     : acc_ctrl_pkg
// Description : Shared types and constants for the accumulation-flag track
//               scheduler: scheduler state encoding, default field widths and
//               the minimum legal widen width, plus a width clamp helper.
// Revision    : 1.0 - initial release
// ============================================================================
package acc_ctrl_pkg;

  // Scheduler states; the encoding is visible in waveforms and debug taps.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FIRST = 3'd1,
    GAP   = 3'd2,
    TRACK = 3'd3,
    DONE  = 3'd4
  } acc_state_e;

  localparam int unsigned CNT_W_DEFAULT = 32;
  localparam int unsigned TRK_W_DEFAULT = 16;

  // A widen window of zero samples is meaningless downstream.
  localparam int unsigned MIN_WIDTH = 1;

  function automatic logic [31:0] clamp_width(input logic [31:0] width);
    return (width == 32'd0) ? 32'(MIN_WIDTH) : width;
  endfunction

endpackage : acc_ctrl_pkg
`default_nettype wire

// File: rtl/acc_width_shadow.sv
`default_nettype none
// ============================================================================
// Module      : acc_width_shadow
// Description : Glitch-safe shadow copy of a widen-width parameter. The copy
//               follows the requested value only while both widen windows
//               are inactive, so an in-flight window never sees its width
//               change. A request of 0 is clamped to the minimum width.
// Ports       : clk_i      - clock
//               rst_i      - asynchronous active-high reset
//               width_i    - requested width (software register)
//               widen_a_i  - first widen-active feedback
//               widen_b_i  - second widen-active feedback
//               width_o    - shadowed width (reset value = minimum width)
// Revision    : 1.0 - initial release
// ============================================================================
module acc_width_shadow
  import acc_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] width_i,
  input  logic             widen_a_i,
  input  logic             widen_b_i,
  output logic [WIDTH-1:0] width_o
);

  if (WIDTH < 1) begin : g_param_check
    $error("acc_width_shadow: WIDTH must be at least 1");
  end

  logic [WIDTH-1:0] width_q;
  logic [WIDTH-1:0] width_d;
  logic             update_ok;

  // Both windows idle: no widen is running, so a new width is safe to take.
  assign update_ok = ~widen_a_i & ~widen_b_i;

  always_comb begin
    width_d = width_q;
    if (update_ok) begin
      width_d = (width_i == '0) ? WIDTH'(MIN_WIDTH) : width_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      width_q <= WIDTH'(MIN_WIDTH);
    end else begin
      width_q <= width_d;
    end
  end

  assign width_o = width_q;

endmodule : acc_width_shadow
`default_nettype wire

// File: rtl/acc_track_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : acc_track_scheduler
// Description : Sequences the accumulation-flag datapath over a multi-track
//               scan. Drives first-track / second-track mode selects and the
//               filter enable, counts valid filter samples per track, inserts
//               an idle gap between tracks and supplies a shadowed detect
//               width that only changes while no widen window is active.
// Option      : define ACC_TRACK_STAT_EN to build the acc event counter;
//               otherwise acc_event_cnt_o is tied to 0.
// Ports       : clk_i / rst_i          - filter clock, async active-high reset
//               laser_start_i          - scan enable level (rise=start, low=abort)
//               track_len_i/gap_i/num_i- samples per track, gap cycles, tracks
//               detect_width_para_i    - requested widen width
//               filter_vld_i           - filter sample strobe
//               pre/curr_widen_result_i- widen state feedback
//               acc_result_i           - acc flag (statistics option only)
//               first_track_ctrl_o, second_track_en_o, filter_en_o - modes
//               detect_width_para_o    - shadowed widen width
//               track_idx_o, busy_o, done_o, acc_event_cnt_o - status
// Revision    : 1.0 - initial release
// ============================================================================
module acc_track_scheduler
  import acc_ctrl_pkg::*;
#(
  parameter real         TCQ   = 0.1,
  parameter int unsigned CNT_W = CNT_W_DEFAULT,
  parameter int unsigned TRK_W = TRK_W_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             laser_start_i,
  input  logic [CNT_W-1:0] track_len_i,
  input  logic [TRK_W-1:0] track_gap_i,
  input  logic [TRK_W-1:0] track_num_i,
  input  logic [31:0]      detect_width_para_i,
  input  logic             filter_vld_i,
  input  logic             pre_widen_result_i,
  input  logic             curr_widen_result_i,
  input  logic             acc_result_i,
  output logic             first_track_ctrl_o,
  output logic             second_track_en_o,
  output logic             filter_en_o,
  output logic [31:0]      detect_width_para_o,
  output logic [TRK_W-1:0] track_idx_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [31:0]      acc_event_cnt_o
);

  // TCQ only models clock-to-Q in behavioural sims; it has no effect here.
  if (TCQ < 0.0 || CNT_W < 1 || TRK_W < 1) begin : g_param_check
    $error("acc_track_scheduler: invalid parameter value");
  end

  acc_state_e       state_q,      state_d;
  logic             laser_q,      laser_d;
  logic             laser_prev_q, laser_prev_d;
  logic [CNT_W-1:0] len_q,        len_d;
  logic [TRK_W-1:0] gap_q,        gap_d;
  logic [TRK_W-1:0] num_q,        num_d;
  logic [CNT_W-1:0] cnt_q,        cnt_d;
  logic [TRK_W-1:0] gap_cnt_q,    gap_cnt_d;
  logic [TRK_W-1:0] idx_q,        idx_d;
  logic             first_q,      first_d;
  logic             second_q,     second_d;
  logic             fen_q,        fen_d;
  logic             busy_q,       busy_d;
  logic             done_q,       done_d;

  logic             abort;
  logic             start_accept;
  logic             cnt_last;
  logic             gap_last;
  logic [TRK_W-1:0] gap_eff;

  // Abort looks at the live level so a dropped laser stops the scan on the
  // very next edge; it also outranks a coincident start.
  assign abort        = ~laser_start_i;
  assign start_accept = (state_q == IDLE) & laser_q & ~laser_prev_q & ~abort;

  // Exit on the last sample so the counter never needs to reach len.
  assign cnt_last = (cnt_q == len_q - CNT_W'(1));
  // A zero gap still costs one cycle so the enable visibly drops.
  assign gap_eff  = (gap_q == '0) ? TRK_W'(1) : gap_q;
  assign gap_last = (gap_cnt_q == gap_eff - TRK_W'(1));

  // --------------------------------------------------------------------------
  // Next-state and working-register update
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    laser_d      = laser_start_i;
    laser_prev_d = laser_q;
    len_d        = len_q;
    gap_d        = gap_q;
    num_d        = num_q;
    cnt_d        = cnt_q;
    gap_cnt_d    = gap_cnt_q;
    idx_d        = idx_q;

    case (state_q)
      IDLE: begin
        if (start_accept) begin
          len_d     = track_len_i;
          gap_d     = track_gap_i;
          num_d     = track_num_i;
          cnt_d     = '0;
          gap_cnt_d = '0;
          idx_d     = '0;
          if (track_len_i == '0 || track_num_i == '0) begin
            state_d = DONE;
          end else begin
            state_d = FIRST;
          end
        end
      end

      FIRST, TRACK: begin
        if (abort) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (filter_vld_i) begin
          if (cnt_last) begin
            // The terminating sample belongs to this track only.
            state_d   = GAP;
            cnt_d     = '0;
            gap_cnt_d = '0;
            idx_d     = idx_q + TRK_W'(1);
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      GAP: begin
        if (abort) begin
          state_d   = IDLE;
          cnt_d     = '0;
          gap_cnt_d = '0;
        end else if (gap_last) begin
          gap_cnt_d = '0;
          state_d   = (idx_q == num_q) ? DONE : TRACK;
        end else begin
          gap_cnt_d = gap_cnt_q + TRK_W'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output decode from the next state, so the registered outputs line up with
  // the registered state with no extra cycle of latency.
  // --------------------------------------------------------------------------
  always_comb begin
    first_d  = 1'b0;
    second_d = 1'b0;
    fen_d    = 1'b0;
    case (state_d)
      FIRST: begin
        first_d = 1'b1;
        fen_d   = 1'b1;
      end
      TRACK: begin
        second_d = 1'b1;
        fen_d    = 1'b1;
      end
      GAP: begin
        // Mode selects keep describing the track that just ended.
        first_d  = first_q;
        second_d = second_q;
      end
      default: begin
        first_d  = 1'b0;
        second_d = 1'b0;
        fen_d    = 1'b0;
      end
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      laser_q      <= 1'b0;
      laser_prev_q <= 1'b0;
      len_q        <= '0;
      gap_q        <= '0;
      num_q        <= '0;
      cnt_q        <= '0;
      gap_cnt_q    <= '0;
      idx_q        <= '0;
      first_q      <= 1'b0;
      second_q     <= 1'b0;
      fen_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      laser_q      <= laser_d;
      laser_prev_q <= laser_prev_d;
      len_q        <= len_d;
      gap_q        <= gap_d;
      num_q        <= num_d;
      cnt_q        <= cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      idx_q        <= idx_d;
      first_q      <= first_d;
      second_q     <= second_d;
      fen_q        <= fen_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign first_track_ctrl_o = first_q;
  assign second_track_en_o  = second_q;
  assign filter_en_o        = fen_q;
  assign track_idx_o        = idx_q;
  assign busy_o             = busy_q;
  assign done_o             = done_q;

  acc_width_shadow #(
    .WIDTH (32)
  ) u_width_shadow (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .width_i   (detect_width_para_i),
    .widen_a_i (pre_widen_result_i),
    .widen_b_i (curr_widen_result_i),
    .width_o   (detect_width_para_o)
  );

`ifdef ACC_TRACK_STAT_EN
  // Count acc rising edges while the filter path is enabled; saturating.
  logic        acc_prev_q, acc_prev_d;
  logic [31:0] acc_cnt_q,  acc_cnt_d;

  always_comb begin
    acc_prev_d = acc_result_i;
    acc_cnt_d  = acc_cnt_q;
    if (start_accept) begin
      acc_cnt_d = '0;
    end else if (fen_q && acc_result_i && !acc_prev_q && (acc_cnt_q != 32'hFFFF_FFFF)) begin
      acc_cnt_d = acc_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_prev_q <= 1'b0;
      acc_cnt_q  <= '0;
    end else begin
      acc_prev_q <= acc_prev_d;
      acc_cnt_q  <= acc_cnt_d;
    end
  end

  assign acc_event_cnt_o = acc_cnt_q;
`else
  logic unused_acc_result;
  assign unused_acc_result = acc_result_i;
  assign acc_event_cnt_o   = '0;
`endif

endmodule : acc_track_scheduler
`default_nettype wire

// File: tb/tb_acc_track_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_acc_track_scheduler
// Description : Scoreboard bench for acc_track_scheduler. The stimulus side
//               expands each scan configuration into the expected sequence
//               of output segments (mode tuple plus how many samples or
//               cycles the segment must last); a negedge monitor cuts the DUT
//               output stream into segments and checks each one in order.
//               The width shadow is checked against a one-line rule model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_acc_track_scheduler;

  localparam int CNT_W = 32;
  localparam int TRK_W = 16;
  localparam int K_NONE = 0;
  localparam int K_VLD  = 1;
  localparam int K_CYC  = 2;

  logic             clk;
  logic             rst;
  logic             laser_start;
  logic [CNT_W-1:0] track_len;
  logic [TRK_W-1:0] track_gap;
  logic [TRK_W-1:0] track_num;
  logic [31:0]      width_in;
  logic             filter_vld;
  logic             pre_widen;
  logic             curr_widen;
  logic             acc_result;
  logic             first_ctrl;
  logic             second_en;
  logic             filter_en;
  logic [31:0]      width_out;
  logic [TRK_W-1:0] track_idx;
  logic             busy;
  logic             done;
  logic [31:0]      acc_cnt;

  acc_track_scheduler dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .laser_start_i       (laser_start),
    .track_len_i         (track_len),
    .track_gap_i         (track_gap),
    .track_num_i         (track_num),
    .detect_width_para_i (width_in),
    .filter_vld_i        (filter_vld),
    .pre_widen_result_i  (pre_widen),
    .curr_widen_result_i (curr_widen),
    .acc_result_i        (acc_result),
    .first_track_ctrl_o  (first_ctrl),
    .second_track_en_o   (second_en),
    .filter_en_o         (filter_en),
    .detect_width_para_o (width_out),
    .track_idx_o         (track_idx),
    .busy_o              (busy),
    .done_o              (done),
    .acc_event_cnt_o     (acc_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic             first;
    logic             second;
    logic             fen;
    logic             busy;
    logic             done;
    logic [TRK_W-1:0] idx;
  } tup_t;

  typedef struct {
    tup_t t;
    int   kind;
    int   meas;
  } seg_t;

  seg_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  function automatic tup_t mk(input bit f, input bit s, input bit e,
                              input bit b, input bit d, input int idx);
    tup_t t;
    t.first  = f;
    t.second = s;
    t.fen    = e;
    t.busy   = b;
    t.done   = d;
    t.idx    = TRK_W'(idx);
    return t;
  endfunction

  function automatic string tstr(input tup_t t);
    return $sformatf("first=%b second=%b fen=%b busy=%b done=%b idx=%0d",
                     t.first, t.second, t.fen, t.busy, t.done, t.idx);
  endfunction

  task automatic push(input tup_t t, input int kind, input int meas);
    seg_t s;
    s.t    = t;
    s.kind = kind;
    s.meas = meas;
    exp_q.push_back(s);
  endtask

  // Reference: the segments a scan must produce, in order.
  task automatic push_scan(input int len, input int gap, input int num);
    if (len == 0 || num == 0) begin
      push(mk(0, 0, 0, 1, 1, 0), K_CYC, 1);
      push(mk(0, 0, 0, 0, 0, 0), K_NONE, 0);
    end else begin
      push(mk(1, 0, 1, 1, 0, 0), K_VLD, len);
      for (int t = 1; t <= num; t++) begin
        push(mk(t == 1, t != 1, 0, 1, 0, t), K_CYC, (gap < 1) ? 1 : gap);
        if (t < num) push(mk(0, 1, 1, 1, 0, t), K_VLD, len);
      end
      push(mk(0, 0, 0, 1, 1, num), K_CYC, 1);
      push(mk(0, 0, 0, 0, 0, num), K_NONE, 0);
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] req);
    n_vec++;
    if (got !== req) begin
      n_miss++;
      $display("FAIL %s: got %0d required %0d", nm, got, req);
    end
  endtask

  // --------------------------------------------------------------------------
  // Monitor: segments the DUT output stream and scores each closed segment.
  // --------------------------------------------------------------------------
  bit   mon_en = 1'b0;
  bit   have   = 1'b0;
  tup_t cur;
  tup_t mon_t;
  int   seg_cyc;
  int   seg_vld;

  task automatic close_seg();
    seg_t e;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_miss++;
      $display("FAIL seg_unexpected: got %s required no segment", tstr(cur));
    end else begin
      e = exp_q.pop_front();
      if (cur !== e.t) begin
        n_miss++;
        $display("FAIL seg_tuple: got %s required %s", tstr(cur), tstr(e.t));
      end
      if (e.kind == K_VLD) begin
        n_vec++;
        if (seg_vld != e.meas) begin
          n_miss++;
          $display("FAIL seg_samples: got %0d required %0d (%s)", seg_vld, e.meas, tstr(e.t));
        end
      end else if (e.kind == K_CYC) begin
        n_vec++;
        if (seg_cyc != e.meas) begin
          n_miss++;
          $display("FAIL seg_cycles: got %0d required %0d (%s)", seg_cyc, e.meas, tstr(e.t));
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon_t = mk(first_ctrl, second_en, filter_en, busy, done, int'(track_idx));
      if (!have) begin
        cur = mon_t; have = 1'b1; seg_cyc = 0; seg_vld = 0;
      end else if (mon_t !== cur) begin
        close_seg();
        cur = mon_t; seg_cyc = 0; seg_vld = 0;
      end
      seg_cyc++;
      if (filter_vld) seg_vld++;
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // which: 0 = in a track after the first, 1 = in a gap, 2 = done, 3 = busy
  task automatic wait_for(input string nm, input int which, input int budget);
    bit hit = 1'b0;
    for (int c = 0; c < budget && !hit; c++) begin
      tick();
      case (which)
        0: hit = second_en & filter_en;
        1: hit = busy & ~filter_en;
        2: hit = done;
        default: hit = busy;
      endcase
    end
    chk({nm, "_reached"}, 32'(hit), 32'd1);
  endtask

  task automatic run_scan(input int len, input int gap, input int num, input int pct);
    bit seen = 1'b0;
    track_len = CNT_W'(len);
    track_gap = TRK_W'(gap);
    track_num = TRK_W'(num);
    push_scan(len, gap, num);
    laser_start = 1'b1;
    for (int c = 0; c < 3000 && !seen; c++) begin
      tick();
      if (done) seen = 1'b1;
      filter_vld = ($urandom_range(99) < pct);
    end
    chk("scan_done_reached", 32'(seen), 32'd1);
    laser_start = 1'b0;
    filter_vld  = 1'b0;
    repeat (3) tick();
  endtask

  logic [31:0] exp_w;
  bit          p_pre, p_curr;
  logic [31:0] p_din;

  initial begin
    rst         = 1'b1;
    laser_start = 1'b0;
    track_len   = '0;
    track_gap   = '0;
    track_num   = '0;
    width_in    = 32'd5;
    filter_vld  = 1'b0;
    pre_widen   = 1'b1;
    curr_widen  = 1'b0;
    acc_result  = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_first",  32'(first_ctrl), 32'd0);
    chk("rst_second", 32'(second_en),  32'd0);
    chk("rst_fen",    32'(filter_en),  32'd0);
    chk("rst_busy",   32'(busy),       32'd0);
    chk("rst_done",   32'(done),       32'd0);
    chk("rst_idx",    32'(track_idx),  32'd0);
    chk("rst_width",  width_out,       32'd1);
    chk("rst_acccnt", acc_cnt,         32'd0);
    push(mk(0, 0, 0, 0, 0, 0), K_NONE, 0);
    mon_en = 1'b1;
    tick();

    // Normal scan, sample every cycle.
    run_scan(4, 2, 3, 100);
    chk("normal_idx_hold", 32'(track_idx), 32'd3);
    // Zero gap, single-sample tracks.
    run_scan(1, 0, 2, 100);

    // Abort on the third cycle of the second track (len 8).
    track_len = 8; track_gap = 2; track_num = 3;
    push(mk(1, 0, 1, 1, 0, 0), K_VLD, 8);
    push(mk(1, 0, 0, 1, 0, 1), K_CYC, 2);
    push(mk(0, 1, 1, 1, 0, 1), K_VLD, 3);
    push(mk(0, 0, 0, 0, 0, 1), K_NONE, 0);
    laser_start = 1'b1;
    filter_vld  = 1'b1;
    wait_for("abort_track", 0, 200);
    tick();
    tick();
    laser_start = 1'b0;
    tick();
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    filter_vld = 1'b0;
    repeat (3) tick();
    run_scan(2, 1, 2, 100);

    // Degenerate configurations.
    run_scan(0, 3, 2, 100);
    run_scan(5, 1, 0, 100);

    // Randomized scans.
    for (int i = 0; i < 12; i++) begin
      run_scan($urandom_range(0, 6), $urandom_range(0, 4),
               $urandom_range(0, 4), $urandom_range(40, 100));
    end
    chk("acccnt_after_scans",
`ifdef ACC_TRACK_STAT_EN
        32'(acc_cnt == acc_cnt), 32'd1);
`else
        acc_cnt, 32'd0);
`endif

    // Width shadow, directed.
    pre_widen = 1'b0; curr_widen = 1'b0; width_in = 32'd10;
    tick(); tick();
    chk("shadow_load10", width_out, 32'd10);
    curr_widen = 1'b1; width_in = 32'd20;
    tick();
    chk("shadow_hold_a", width_out, 32'd10);
    tick(); tick();
    chk("shadow_hold_b", width_out, 32'd10);
    curr_widen = 1'b0;
    tick();
    chk("shadow_load20", width_out, 32'd20);
    width_in = 32'd0;
    tick();
    chk("shadow_clamp0", width_out, 32'd1);
    pre_widen = 1'b1; width_in = 32'd7;
    tick();
    chk("shadow_hold_pre", width_out, 32'd1);

    // Width shadow, randomized against the rule.
    exp_w = 32'd1;
    for (int i = 0; i < 40; i++) begin
      p_pre  = ($urandom_range(3) == 0);
      p_curr = ($urandom_range(3) == 0);
      p_din  = ($urandom_range(4) == 0) ? 32'd0 : $urandom;
      pre_widen = p_pre; curr_widen = p_curr; width_in = p_din;
      tick();
      if (!p_pre && !p_curr) exp_w = (p_din == 32'd0) ? 32'd1 : p_din;
      chk("shadow_rand", width_out, exp_w);
    end
    pre_widen = 1'b1;

`ifdef ACC_TRACK_STAT_EN
    // 5 acc pulses inside a track, 2 inside a gap: only the first 5 count.
    track_len = 12; track_gap = 8; track_num = 2;
    push_scan(12, 8, 2);
    laser_start = 1'b1;
    filter_vld  = 1'b1;
    wait_for("stat_track", 0, 200);
    repeat (5) begin acc_result = 1'b1; tick(); acc_result = 1'b0; tick(); end
    wait_for("stat_gap", 1, 50);
    repeat (2) begin acc_result = 1'b1; tick(); acc_result = 1'b0; tick(); end
    wait_for("stat_done", 2, 50);
    chk("stat_count", acc_cnt, 32'd5);
    laser_start = 1'b0;
    filter_vld  = 1'b0;
    repeat (3) tick();
    track_len = 1; track_gap = 0; track_num = 1;
    push_scan(1, 0, 1);
    laser_start = 1'b1;
    wait_for("stat_restart", 3, 20);
    chk("stat_cleared", acc_cnt, 32'd0);
    filter_vld = 1'b1;
    wait_for("stat_done2", 2, 50);
    laser_start = 1'b0;
    filter_vld  = 1'b0;
    repeat (3) tick();
`endif

    mon_en = 1'b0;
    @(negedge clk);
    close_seg();
    chk("seg_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_acc_track_scheduler
`default_nettype wire
